alu_op_sequencer: RTL and testbench

Initiator-side controller for the datapath ALU. It accepts a command (operands, operation, shift request, flag update, branch condition) over a valid/ready handshake. It drives the ALU control and operand buses, iterates multi-bit shifts through the ALU's 1-step shift stage, and reads back busC and the registered C/N/P/Z flags. It returns the result and an evaluated branch condition over a valid/ready response port. It sits between the control unit and the ALU.

---
 rtl/alu_op_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Initiator-side controller that sits between the control unit and the
// datapath ALU.  It accepts one command at a time over a valid/ready port.
// It drives the ALU buses for a first pass, which applies the operation and
// the first shift step.  It then iterates any remaining shift steps through
// the ALU's 1-step shifter using the pass-A operation.  It evaluates a branch
// condition against the registered ALU flags and returns the result over a
// valid/ready response port.
//
// Optional build macro: ALU_SEQ_BYPASS_EN
//   When defined, a command with setf=0 and an unconditional condition
//   (000 always / 111 never) skips the EVAL cycle.  Its condition result is
//   a constant.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   cmd_valid/ready     command handshake
//   cmd_op, cmd_a/b     first-pass ALU operation and operands
//   cmd_shdir, shcnt    shift kind (ALU shamt encoding) and step count 0..7
//   cmd_setf            let the first pass update the ALU flag register
//   cmd_cond            branch condition selector
//   rsp_valid/ready     response handshake
//   rsp_data, rsp_cond  final result and evaluated condition
//   alu_busA/B, selop, shamt, enaf   drive the ALU
//   alu_busC, alu_C/N/P/Z            ALU result and registered flags
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int         MAX_WIDTH = 8,
    parameter logic [2:0] PASSA_OP  = 3'b000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [MAX_WIDTH-1:0] cmd_a,
    input  logic [MAX_WIDTH-1:0] cmd_b,
    input  logic [1:0]           cmd_shdir,
    input  logic [2:0]           cmd_shcnt,
    input  logic                 cmd_setf,
    input  logic [2:0]           cmd_cond,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [MAX_WIDTH-1:0] rsp_data,
    output logic                 rsp_cond,
    output logic [MAX_WIDTH-1:0] alu_busA,
    output logic [MAX_WIDTH-1:0] alu_busB,
    output logic [2:0]           alu_selop,
    output logic [1:0]           alu_shamt,
    output logic                 alu_enaf,
    input  logic [MAX_WIDTH-1:0] alu_busC,
    input  logic                 alu_C,
    input  logic                 alu_N,
    input  logic                 alu_P,
    input  logic                 alu_Z
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        SHIFT = 3'd2,
        EVAL  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [MAX_WIDTH-1:0]   a_q, a_d;
    logic [MAX_WIDTH-1:0]   b_q, b_d;
    logic [2:0]             op_q, op_d;
    logic [1:0]             shdir_q, shdir_d;
    logic [2:0]             shcnt_q, shcnt_d;
    logic                   setf_q, setf_d;
    logic [2:0]             cc_q, cc_d;
    logic [2:0]             rem_q, rem_d;
    logic [MAX_WIDTH-1:0]   res_q, res_d;
    logic                   cond_r_q, cond_r_d;

    logic [MAX_WIDTH-1:0]   alu_busa_q, alu_busa_d;
    logic [MAX_WIDTH-1:0]   alu_busb_q, alu_busb_d;
    logic [2:0]             alu_selop_q, alu_selop_d;
    logic [1:0]             alu_shamt_q, alu_shamt_d;
    logic                   alu_enaf_q, alu_enaf_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [MAX_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                   rsp_cond_q, rsp_cond_d;

    logic                   skip_eval;

    function automatic logic eval_cond(input logic [2:0] sel, input logic fc,
                                       input logic fn, input logic fp,
                                       input logic fz);
        logic r;
        case (sel)
            3'b000:  r = 1'b1;
            3'b001:  r = fz;
            3'b010:  r = ~fz;
            3'b011:  r = fc;
            3'b100:  r = ~fc;
            3'b101:  r = fn;
            3'b110:  r = fp;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // A command whose condition cannot depend on flags it did not write
    // itself (always/never with setf=0) can go straight to the response.
`ifdef ALU_SEQ_BYPASS_EN
    assign skip_eval = ~setf_q & ((cc_q == 3'b000) | (cc_q == 3'b111));
`else
    assign skip_eval = 1'b0;
`endif

    // Accept is gated by reset so nothing is offered while rst is low.
    assign cmd_ready = rst & (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        shdir_d  = shdir_q;
        shcnt_d  = shcnt_q;
        setf_d   = setf_q;
        cc_d     = cc_q;
        rem_d    = rem_q;
        res_d    = res_q;
        cond_r_d = cond_r_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    op_d    = cmd_op;
                    shdir_d = cmd_shdir;
                    shcnt_d = cmd_shcnt;
                    setf_d  = cmd_setf;
                    cc_d    = cmd_cond;
                    // The first pass already performs one shift step.
                    rem_d   = (cmd_shcnt == 3'd0) ? 3'd0 : cmd_shcnt - 3'd1;
                    state_d = ISSUE;
                end
            end
            ISSUE, SHIFT: begin
                res_d = alu_busC;
                if (state_q == SHIFT) begin
                    rem_d = rem_q - 3'd1;
                end
                if ((state_q == ISSUE && rem_q != 3'd0) ||
                    (state_q == SHIFT && rem_q != 3'd1)) begin
                    state_d = SHIFT;
                end else if (skip_eval) begin
                    cond_r_d = (cc_q == 3'b000);
                    state_d  = RESP;
                end else begin
                    state_d = EVAL;
                end
            end
            EVAL: begin
                // Flags written at the ISSUE edge are visible by now.
                cond_r_d = eval_cond(cc_q, alu_C, alu_N, alu_P, alu_Z);
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered.
        alu_busa_d  = '0;
        alu_busb_d  = '0;
        alu_selop_d = '0;
        alu_shamt_d = '0;
        alu_enaf_d  = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = '0;
        rsp_cond_d  = 1'b0;
        case (state_d)
            ISSUE: begin
                alu_busa_d  = a_d;
                alu_busb_d  = b_d;
                alu_selop_d = op_d;
                alu_shamt_d = (shcnt_d == 3'd0) ? 2'b00 : shdir_d;
                alu_enaf_d  = setf_d;
            end
            SHIFT: begin
                alu_busa_d  = res_d;
                alu_selop_d = PASSA_OP;
                alu_shamt_d = shdir_d;
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = res_d;
                rsp_cond_d  = cond_r_d;
            end
            default: ;
        endcase
    end

    // Single state register; reset clears everything, aborting any command.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            shdir_q     <= '0;
            shcnt_q     <= '0;
            setf_q      <= 1'b0;
            cc_q        <= '0;
            rem_q       <= '0;
            res_q       <= '0;
            cond_r_q    <= 1'b0;
            alu_busa_q  <= '0;
            alu_busb_q  <= '0;
            alu_selop_q <= '0;
            alu_shamt_q <= '0;
            alu_enaf_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_cond_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            shdir_q     <= shdir_d;
            shcnt_q     <= shcnt_d;
            setf_q      <= setf_d;
            cc_q        <= cc_d;
            rem_q       <= rem_d;
            res_q       <= res_d;
            cond_r_q    <= cond_r_d;
            alu_busa_q  <= alu_busa_d;
            alu_busb_q  <= alu_busb_d;
            alu_selop_q <= alu_selop_d;
            alu_shamt_q <= alu_shamt_d;
            alu_enaf_q  <= alu_enaf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_cond_q  <= rsp_cond_d;
        end
    end

    assign alu_busA  = alu_busa_q;
    assign alu_busB  = alu_busb_q;
    assign alu_selop = alu_selop_q;
    assign alu_shamt = alu_shamt_q;
    assign alu_enaf  = alu_enaf_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cond  = rsp_cond_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Bench for alu_op_sequencer.  A small behavioural ALU closes the loop: it
// is combinational on the buses and has a flag register written when enaf is
// high.  For every command the bench predicts the following:
//   - the per-cycle bus activity,
//   - the result and the condition,
//   - the response latency.
// A monitor compares the DUT against that prediction on every cycle.
// Directed commands also carry hand-computed result/condition literals.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int         W    = 8;
    localparam logic [2:0] PASS = 3'b000;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [2:0]     cmd_op = '0;
    logic [W-1:0]   cmd_a = '0;
    logic [W-1:0]   cmd_b = '0;
    logic [1:0]     cmd_shdir = '0;
    logic [2:0]     cmd_shcnt = '0;
    logic           cmd_setf = 1'b0;
    logic [2:0]     cmd_cond = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [W-1:0]   rsp_data;
    logic           rsp_cond;
    logic [W-1:0]   alu_busA, alu_busB, alu_busC;
    logic [2:0]     alu_selop;
    logic [1:0]     alu_shamt;
    logic           alu_enaf;
    logic           fC = 1'b0, fN = 1'b0, fP = 1'b0, fZ = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.MAX_WIDTH(W), .PASSA_OP(PASS)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_shdir(cmd_shdir), .cmd_shcnt(cmd_shcnt),
        .cmd_setf(cmd_setf), .cmd_cond(cmd_cond),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_cond(rsp_cond),
        .alu_busA(alu_busA), .alu_busB(alu_busB), .alu_selop(alu_selop),
        .alu_shamt(alu_shamt), .alu_enaf(alu_enaf), .alu_busC(alu_busC),
        .alu_C(fC), .alu_N(fN), .alu_P(fP), .alu_Z(fZ)
    );

    // ALU operation: {carry, result}.
    function automatic logic [8:0] aluOp(input logic [2:0] op,
                                         input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'b000:  return {1'b0, a};
            3'b001:  return {1'b0, a} + {1'b0, b};
            3'b010:  return {1'b0, a} - {1'b0, b};
            3'b011:  return {1'b0, a & b};
            3'b100:  return {1'b0, a | b};
            3'b101:  return {1'b0, a ^ b};
            3'b110:  return {1'b0, ~a};
            default: return {1'b0, b};
        endcase
    endfunction

    function automatic logic [7:0] shiftOne(input logic [7:0] v, input logic [1:0] d);
        case (d)
            2'b01:   return v << 1;
            2'b10:   return v >> 1;
            2'b11:   return {v[7], v[7:1]};
            default: return v;
        endcase
    endfunction

    function automatic logic condOf(input logic [2:0] c, input logic xc,
                                    input logic xn, input logic xp, input logic xz);
        case (c)
            3'd0: return 1'b1;
            3'd1: return xz;
            3'd2: return !xz;
            3'd3: return xc;
            3'd4: return !xc;
            3'd5: return xn;
            3'd6: return xp;
            default: return 1'b0;
        endcase
    endfunction

    // Behavioural ALU: combinational result, flags from the unshifted result.
    logic [8:0] aluRaw;
    always_comb aluRaw = aluOp(alu_selop, alu_busA, alu_busB);
    assign alu_busC = shiftOne(aluRaw[7:0], alu_shamt);

    always @(posedge clk) begin
        if (!rst) begin
            fC <= 1'b0; fN <= 1'b0; fP <= 1'b0; fZ <= 1'b0;
        end else if (alu_enaf) begin
            fC <= aluRaw[8];
            fN <= aluRaw[7];
            fZ <= (aluRaw[7:0] == 8'h00);
            fP <= !aluRaw[7] && (aluRaw[7:0] != 8'h00);
        end
    end

    // Prediction for the command in flight.
    logic       mC = 0, mN = 0, mP = 0, mZ = 0;
    logic [7:0] expStep [0:7];
    logic [7:0] expA = 0, expB = 0, expData = 0;
    logic [2:0] expOp = 0, expShcnt = 0;
    logic [1:0] expShdir = 0;
    logic       expSetf = 0, expCond = 0;
    int         expLat = 3;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // Cycles since accept: ISSUE is cycle 1, 0 means nothing in flight.
    int k = 0;
    bit rstSeen = 0;
    always @(posedge clk) begin
        if (!rst) begin
            k <= 0;
            rstSeen <= 1'b1;
        end else begin
            rstSeen <= 1'b0;
            if (cmd_valid && cmd_ready)           k <= 1;
            else if (k != 0 && rsp_valid && rsp_ready) k <= 0;
            else if (k != 0)                      k <= k + 1;
        end
    end

    // Compare process: checks every cycle against the prediction.
    always @(negedge clk) begin
        if (!rst) begin
            if (rstSeen) begin
                checkOutput("reset_cmd_ready", 32'(cmd_ready), 0);
                checkOutput("reset_rsp_valid", 32'(rsp_valid), 0);
                checkOutput("reset_alu_bus",
                    32'({alu_busA, alu_busB, alu_selop, alu_shamt, alu_enaf}), 0);
            end
        end else if (k == 0) begin
            checkOutput("idle_cmd_ready", 32'(cmd_ready), 1);
            checkOutput("idle_rsp_valid", 32'(rsp_valid), 0);
            checkOutput("idle_alu_bus",
                32'({alu_busA, alu_busB, alu_selop, alu_shamt, alu_enaf}), 0);
        end else begin
            checkOutput("busy_cmd_ready", 32'(cmd_ready), 0);
            checkOutput("rsp_valid_timing", 32'(rsp_valid), 32'(k >= expLat));
            if (k == 1)
                checkOutput("issue_bus",
                    32'({alu_busA, alu_busB, alu_selop, alu_shamt, alu_enaf}),
                    32'({expA, expB, expOp,
                         (expShcnt == 3'd0) ? 2'b00 : expShdir, expSetf}));
            else if (k <= int'(expShcnt))
                checkOutput("shift_bus",
                    32'({alu_busA, alu_busB, alu_selop, alu_shamt, alu_enaf}),
                    32'({expStep[k-1], 8'h00, PASS, expShdir, 1'b0}));
            else
                checkOutput("quiet_bus",
                    32'({alu_busA, alu_busB, alu_selop, alu_shamt, alu_enaf}), 0);
            if (k >= expLat) begin
                checkOutput("rsp_data", 32'(rsp_data), 32'(expData));
                checkOutput("rsp_cond", 32'(rsp_cond), 32'(expCond));
            end
        end
    end

    task automatic doReset(input int cycles);
        #1;
        rst = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        mC = 0; mN = 0; mP = 0; mZ = 0;
        #1;
        checkOutput("cmd_ready_after_reset", 32'(cmd_ready), 1);
        checkOutput("rsp_valid_after_reset", 32'(rsp_valid), 0);
    endtask

    // Predict the command, then present it and wait for the accept edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic [1:0] shdir,
                                 input logic [2:0] shcnt, input logic setf,
                                 input logic [2:0] cond);
        logic [8:0] r;
        int n;
        r = aluOp(op, a, b);
        expStep[0] = r[7:0];
        for (int j = 1; j < 8; j++) expStep[j] = shiftOne(expStep[j-1], shdir);
        expData = expStep[shcnt];
        if (setf) begin
            mC = r[8]; mN = r[7]; mZ = (r[7:0] == 8'h00);
            mP = !r[7] && (r[7:0] != 8'h00);
        end
        expCond = condOf(cond, mC, mN, mP, mZ);
        expLat = (shcnt <= 3'd1) ? 3 : 2 + int'(shcnt);
`ifdef ALU_SEQ_BYPASS_EN
        if (!setf && (cond == 3'b000 || cond == 3'b111)) expLat = expLat - 1;
`endif
        expA = a; expB = b; expOp = op; expShdir = shdir;
        expShcnt = shcnt; expSetf = setf;

        @(negedge clk);
        #1;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_shdir = shdir;
        cmd_shcnt = shcnt; cmd_setf = setf; cmd_cond = cond;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checkOutput("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for the response, hold off rsp_ready, then consume it.
    task automatic waitResponse(input int hold, input logic [7:0] litData,
                                input logic litCond);
        int n;
        checkOutput("model_data_literal", 32'(expData), 32'(litData));
        checkOutput("model_cond_literal", 32'(expCond), 32'(litCond));
        @(negedge clk);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            checkOutput("rsp_timeout", 0, 1);
            return;
        end
        checkOutput("rsp_data_literal", 32'(rsp_data), 32'(litData));
        checkOutput("rsp_cond_literal", 32'(rsp_cond), 32'(litCond));
        repeat (hold) @(negedge clk);
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        doReset(3);

        $display("[TB] add with N condition");
        applyStimulus(3'b001, 8'h7F, 8'h01, 2'b00, 3'd0, 1'b1, 3'b101);
        waitResponse(0, 8'h80, 1'b1);

        $display("[TB] seven-step left shift");
        applyStimulus(3'b000, 8'h01, 8'h00, 2'b01, 3'd7, 1'b1, 3'b001);
        waitResponse(0, 8'h80, 1'b0);

        $display("[TB] flag retention");
        applyStimulus(3'b001, 8'hFF, 8'h01, 2'b00, 3'd0, 1'b1, 3'b000);
        waitResponse(0, 8'h00, 1'b1);
        applyStimulus(3'b001, 8'h01, 8'h01, 2'b00, 3'd0, 1'b0, 3'b001);
        waitResponse(0, 8'h02, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(3'b001, 8'h3C, 8'h05, 2'b10, 3'd2, 1'b1, 3'b110);
        waitResponse(5, 8'h10, 1'b1);

        $display("[TB] carry and never");
        applyStimulus(3'b001, 8'hFF, 8'h01, 2'b00, 3'd0, 1'b1, 3'b011);
        waitResponse(0, 8'h00, 1'b1);
        applyStimulus(3'b001, 8'hFF, 8'h01, 2'b00, 3'd0, 1'b1, 3'b111);
        waitResponse(0, 8'h00, 1'b0);

        $display("[TB] arithmetic shift, no-shift kind, single step");
        applyStimulus(3'b000, 8'h90, 8'h00, 2'b11, 3'd3, 1'b0, 3'b000);
        waitResponse(2, 8'hF2, 1'b1);
        applyStimulus(3'b011, 8'hF0, 8'h3C, 2'b00, 3'd4, 1'b1, 3'b010);
        waitResponse(0, 8'h30, 1'b1);
        applyStimulus(3'b001, 8'h40, 8'h40, 2'b01, 3'd1, 1'b1, 3'b001);
        waitResponse(1, 8'h00, 1'b0);

        $display("[TB] reset during shift");
        applyStimulus(3'b000, 8'h03, 8'h00, 2'b01, 3'd5, 1'b0, 3'b000);
        repeat (2) @(negedge clk);
        doReset(3);
        repeat (4) @(negedge clk);

        $display("[TB] command after reset");
        applyStimulus(3'b111, 8'h00, 8'h5A, 2'b00, 3'd0, 1'b1, 3'b100);
        waitResponse(0, 8'h5A, 1'b1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
